// File: rtl/div_seq_32.sv
// Sequential 32-bit restoring divider (signed/unsigned): 34-cycle latency, 1 cycle on divide-by-zero.
// No backpressure: START is only accepted in IDLE and ignored while BUSY; results hold until the next DONE.

module RC_ADD_SUB_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SnA,
  output logic [31:0] Y,
  output logic        CO
);
  always_comb begin : ripple
    logic        carry;
    logic [31:0] bx;
    Y     = '0;
    bx    = B ^ {32{SnA}};
    carry = SnA;
    for (int i = 0; i < 32; i++) begin
      Y[i]  = A[i] ^ bx[i] ^ carry;
      carry = (A[i] & bx[i]) | (carry & (A[i] ^ bx[i]));
    end
    CO = carry;
  end
endmodule

module div_seq_32 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        BUSY,
  output logic        DONE,
  output logic        DIV_ZERO
);
  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] p_q, p_d;
  logic [31:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [31:0] shifted;
  logic [31:0] add_y;
  logic        add_co;
  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign shifted = {p_q[30:0], shreg_q[31]};
  // P[31] set means the 33-bit shifted value already exceeds any 32-bit divisor.
  assign accept  = add_co | p_q[31];
  assign a_mag   = (sgn_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign b_mag   = (sgn_q && b_q[31]) ? (~b_q + 32'd1) : b_q;

  RC_ADD_SUB_32 u_addsub (
    .A   (shifted),
    .B   (b_q),
    .SnA (1'b1),
    .Y   (add_y),
    .CO  (add_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    p_d     = p_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = SIGNED;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        if (b_q == 32'd0) begin
          q_d     = 32'hFFFF_FFFF;
          r_d     = a_q;
          dz_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          b_d     = b_mag;
          shreg_d = a_mag;
          p_d     = 32'd0;
          cnt_d   = 5'd0;
          qneg_d  = sgn_q & (a_q[31] ^ b_q[31]);
          rneg_d  = sgn_q & a_q[31];
          state_d = ITER;
        end
      end
      ITER: begin
        p_d     = accept ? add_y : shifted;
        shreg_d = {shreg_q[30:0], accept};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        q_d     = qneg_q ? (~shreg_q + 32'd1) : shreg_q;
        r_d     = rneg_q ? (~p_q + 32'd1) : p_q;
        dz_d    = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign DIV_ZERO = dz_q;
endmodule
